pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline. It generates per-stage enable and flush (bubble-insert) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- It resolves three conditions: load-use hazards, taken branches and multi-cycle data-memory waits.
- It provides a saturating stall counter and a sticky memory-timeout error.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, stall counter width.
- MEM_WAIT_MAX, 15, maximum MEM_WAIT cycles before error; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  REG_AW  source reg 1 of instruction in ID.
- id_rs2  in  REG_AW  source reg 2 of instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_AW  destination of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes access this cycle.
- pc_en  out  1  PC load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads all-zero (NOP) instead of its input; acts only when the matching en=1.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating at all-ones.
- err  out  1  sticky memory-timeout error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: RUN, MEM_WAIT, ERROR. Internal 8-bit wait timer.
- While rst=1:
  - All en=1 and all flush=1, so the pipeline registers clear to NOP on the edge.
  - pc_en=0.
  - Next state RUN, timer=0, err=0, stall_cnt=0.
  - Reset asserted in any state, including mid-MEM_WAIT or ERROR, returns to RUN.
- Outputs are combinational from state and current inputs. There is no added latency; decisions apply to the same edge.
- Defaults in RUN: all en=1, all flush=0.
- Priority in RUN, highest first: memory stall > branch flush > load-use.
- Memory stall (RUN, mem_req=1, mem_ready=0):
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_en=1 and mem_wb_flush=1, inserting a bubble into WB.
  - Next state MEM_WAIT, timer=1.
  - mem_req=1 with mem_ready=1 in the same cycle causes no stall.
- MEM_WAIT:
  - Outputs match the memory-stall outputs while mem_ready=0; timer increments each cycle.
  - mem_ready=1: outputs revert to RUN rules evaluated this cycle (branch/load-use still apply). Next state RUN, timer=0.
  - timer==MEM_WAIT_MAX and mem_ready=0: next state ERROR.
- ERROR:
  - All en=0, all flush=0; err=1.
  - Held until rst.
- Load-use:
  - Hazard = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1, mem_wb_en=1.
  - Exactly one stall cycle per hazard, because the bubble removes the load from EX.
  - ex_rd==0 never stalls.
- Branch taken:
  - if_id_flush=1, id_ex_flush=1, pc_en=1 (PC loads the target).
  - Overrides a simultaneous load-use hazard: the ID instruction is wrong-path, so there is no stall.
- stall_cnt:
  - Increments on each edge where rst=0 and pc_en=0, ERROR included.
  - Saturates at 2^CNT_W-1; never wraps.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - the default REG_AW;
  - the timer width constant.
- Sub-module hazard_detect: purely combinational load-use comparator with inputs id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read and output lu_hazard.
- The FSM, timer and counter remain in pipeline_ctrl.

Test Plan:
- Reset: hold rst=1 for 2 cycles → all flush=1, pc_en=0, stall_cnt=0, err=0. Release → all en=1, flush=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rd=0 → no stall; stall_cnt=1 after the first case.
- Branch + load-use same cycle: ex_branch_taken=1 with hazard active → if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high → 3 cycles with pc_en, if_id_en, id_ex_en, ex_mem_en = 0 and mem_wb_flush=1. Normal flow on the ready cycle; stall_cnt += 3.
- Timeout: MEM_WAIT_MAX=4, mem_ready never asserted → ERROR entered, err=1, all en=0 held. rst=1 clears err and returns to RUN.
- Saturation: CNT_W=3, force 10 stall cycles → stall_cnt stops at 7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    // Default register-index width (32 architectural registers)
    localparam int REG_AW_DEF = 5;

    // Width of the internal memory-wait timer
    localparam int TIMER_W = 8;

    // Controller states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently sitting in EX. Register 0 is hardwired
// to zero, so it can never carry a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu_hazard
);

    logic rdNonZero;
    logic rs1Match;
    logic rs2Match;

    // Compare the EX load destination against both ID sources
    always_comb begin
        rdNonZero = (ex_rd != '0);
        rs1Match  = (ex_rd == id_rs1);
        rs2Match  = id_uses_rs2 && (ex_rd == id_rs2);
        lu_hazard = ex_mem_read && rdNonZero && (rs1Match || rs2Match);
    end

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// Central sequencing controller for the 5-stage pipeline. Produces the
// per-stage enable/flush controls, tracks multi-cycle memory waits with a
// timeout, and counts cycles in which the PC was held.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              err
);

    localparam logic [TIMER_W-1:0] WAIT_MAX = TIMER_W'(MEM_WAIT_MAX);

    ctrl_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stallCnt_q;
    logic               luHazard;
    logic               memStall;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hazard   (luHazard)
    );

    // A new miss stalls from RUN; once waiting, only mem_ready releases it
    always_comb begin
        memStall = 1'b0;
        if (state_q == RUN) begin
            memStall = mem_req && !mem_ready;
        end else if (state_q == MEM_WAIT) begin
            memStall = !mem_ready;
        end
    end

    // Stage controls and next state; reset clears every register to NOP,
    // then memory stall beats branch flush, which beats load-use
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_d      = state_q;
        timer_d      = timer_q;
        err_d        = err_q;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
            timer_d      = '0;
            err_d        = 1'b0;
        end else if (state_q != RUN && state_q != MEM_WAIT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_d   = ERROR;
            err_d     = 1'b1;
        end else if (memStall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            if (state_q == RUN) begin
                state_d = MEM_WAIT;
                timer_d = TIMER_W'(1);
            end else if (timer_q == WAIT_MAX) begin
                state_d = ERROR;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            state_d = RUN;
            timer_d = '0;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (luHazard) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // State, wait timer, sticky error and saturating stall counter
    always_ff @(posedge clk) begin
        state_q <= state_d;
        timer_q <= timer_d;
        err_q   <= err_d;
        if (rst) begin
            stallCnt_q <= '0;
        end else if (!pc_en && !(&stallCnt_q)) begin
            stallCnt_q <= stallCnt_q + 1'b1;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign err       = err_q;

endmodule : pipeline_ctrl
